// File: rtl/nf10_oq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nf10_oq_pkg
//  Description : Shared types and helpers for the parametrised output-queue
//                stage: FSM state type, destination field default, ceil-log2
//                and a saturating 32-bit increment.
//  Revision    : 1.0 - initial release
// ============================================================================
package nf10_oq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR_PKT = 2'd1,
        DROP   = 2'd2
    } oq_state_t;

    // Default bit position of the destination bitmap inside tuser
    localparam int DST_FIELD_LSB = 24;

    // Ceiling log2; log2(1) = 0
    function automatic int log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // Counters stick at all-ones instead of wrapping
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nf10_oq_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : nf10_oq_fifo
//  Description : First-word-fall-through FIFO with occupancy count. A write
//                to a full FIFO is ignored; a read of an empty FIFO is ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module nf10_oq_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_wr_en,
    input  logic [WIDTH-1:0]      i_din,
    input  logic                  i_rd_en,
    output logic [WIDTH-1:0]      o_dout,
    output logic                  o_empty,
    output logic [DEPTH_BITS:0]   o_count
);

    localparam int                c_DEPTH = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] c_FULL = {1'b1, {DEPTH_BITS{1'b0}}};

    logic [WIDTH-1:0]      r_mem [c_DEPTH];
    logic [DEPTH_BITS-1:0] r_wr_ptr;
    logic [DEPTH_BITS-1:0] r_rd_ptr;
    logic [DEPTH_BITS:0]   r_count;

    logic w_push;
    logic w_pop;

    assign w_push  = i_wr_en & (r_count != c_FULL);
    assign w_pop   = i_rd_en & (r_count != '0);
    assign o_dout  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

    // Storage array, no reset so it maps onto block memory
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_din;
    end

    // Pointers and occupancy; simultaneous push and pop keeps the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/nf10_param_output_queues.sv
`default_nettype none
// ============================================================================
//  Module      : nf10_param_output_queues
//  Description : AXI4-Stream output-queue stage. Routes each packet to the
//                queues in its tuser bitmap, admitting it only if every
//                selected queue can hold a maximum-size packet. Keeps
//                saturating per-queue packet/drop counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module nf10_param_output_queues
    import nf10_oq_pkg::*;
#(
    parameter int C_AXIS_DATA_WIDTH = 256,
    parameter int C_USER_WIDTH      = 128,
    parameter int NUM_QUEUES        = 5,
    parameter int QUEUE_DEPTH_BITS  = 9,
    parameter int MAX_PKT_WORDS     = 48,
    parameter int C_DST_LSB         = DST_FIELD_LSB
) (
    input  logic                                      axi_aclk,
    input  logic                                      axi_resetn,
    input  logic [C_AXIS_DATA_WIDTH-1:0]              s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]            s_axis_tstrb,
    input  logic [C_USER_WIDTH-1:0]                   s_axis_tuser,
    input  logic                                      s_axis_tvalid,
    output logic                                      s_axis_tready,
    input  logic                                      s_axis_tlast,
    output logic [NUM_QUEUES*C_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [NUM_QUEUES*C_AXIS_DATA_WIDTH/8-1:0] m_axis_tstrb,
    output logic [NUM_QUEUES*C_USER_WIDTH-1:0]        m_axis_tuser,
    output logic [NUM_QUEUES-1:0]                     m_axis_tvalid,
    input  logic [NUM_QUEUES-1:0]                     m_axis_tready,
    output logic [NUM_QUEUES-1:0]                     m_axis_tlast,
    output logic [NUM_QUEUES*32-1:0]                  pkt_cnt,
    output logic [NUM_QUEUES*32-1:0]                  drop_cnt,
    output logic [31:0]                               null_drop_cnt
);

    localparam int c_DW     = C_AXIS_DATA_WIDTH;
    localparam int c_SW     = C_AXIS_DATA_WIDTH / 8;
    localparam int c_UW     = C_USER_WIDTH;
    localparam int c_FIFO_W = c_DW + c_SW + c_UW + 1;
    localparam int c_DEPTH  = 1 << QUEUE_DEPTH_BITS;
    localparam int c_CNT_W  = log2(c_DEPTH) + 1;
    // Highest occupancy that still leaves room for a maximum-size packet
    localparam logic [c_CNT_W-1:0] c_ADMIT_OCC = c_CNT_W'(c_DEPTH - MAX_PKT_WORDS);

    oq_state_t               r_state;
    logic                    r_tready;
    logic [NUM_QUEUES-1:0]   r_cur_q;
    logic [NUM_QUEUES*32-1:0] r_pkt_cnt;
    logic [NUM_QUEUES*32-1:0] r_drop_cnt;
    logic [31:0]             r_null_cnt;

    logic [NUM_QUEUES-1:0]   w_dst;
    logic [NUM_QUEUES-1:0]   w_room;
    logic [NUM_QUEUES-1:0]   w_wr_en;
    logic [NUM_QUEUES-1:0]   w_rd_en;
    logic [NUM_QUEUES-1:0]   w_empty;
    logic [NUM_QUEUES-1:0]   w_pkt_done;
    logic [NUM_QUEUES-1:0]   w_drop_hit;
    logic                    w_null_hit;
    logic                    w_beat;
    logic                    w_admit;
    logic [c_CNT_W-1:0]      w_count     [NUM_QUEUES];
    logic [c_FIFO_W-1:0]     w_fifo_dout [NUM_QUEUES];

    assign w_dst   = s_axis_tuser[C_DST_LSB +: NUM_QUEUES];
    assign w_beat  = s_axis_tvalid & r_tready;
    assign w_admit = (w_dst != '0) && ((w_dst & ~w_room) == '0);

    assign s_axis_tready = r_tready;
    assign pkt_cnt       = r_pkt_cnt;
    assign drop_cnt      = r_drop_cnt;
    assign null_drop_cnt = r_null_cnt;

    // Per-beat write enables and counter events decoded from the FSM state
    always_comb begin
        w_wr_en    = '0;
        w_pkt_done = '0;
        w_drop_hit = '0;
        w_null_hit = 1'b0;
        if (w_beat) begin
            case (r_state)
                IDLE: begin
                    if (w_admit) begin
                        w_wr_en = w_dst;
                        if (s_axis_tlast) w_pkt_done = w_dst;
                    end else begin
                        w_drop_hit = w_dst & ~w_room;
                        w_null_hit = (w_dst == '0);
                    end
                end
                WR_PKT: begin
                    w_wr_en = r_cur_q;
                    if (s_axis_tlast) w_pkt_done = r_cur_q;
                end
                default: ;
            endcase
        end
    end

    // Packet FSM: routing is fixed by the first beat of each packet
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            r_state  <= IDLE;
            r_tready <= 1'b0;
            r_cur_q  <= '0;
        end else begin
            r_tready <= 1'b1;
            if (w_beat) begin
                case (r_state)
                    IDLE: begin
                        if (w_admit) r_cur_q <= w_dst;
                        if (!s_axis_tlast) r_state <= w_admit ? WR_PKT : DROP;
                    end
                    WR_PKT, DROP: begin
                        if (s_axis_tlast) r_state <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    // Saturating statistics counters
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            r_pkt_cnt  <= '0;
            r_drop_cnt <= '0;
            r_null_cnt <= '0;
        end else begin
            for (int q = 0; q < NUM_QUEUES; q++) begin
                if (w_pkt_done[q]) r_pkt_cnt[q*32 +: 32]  <= sat_inc(r_pkt_cnt[q*32 +: 32]);
                if (w_drop_hit[q]) r_drop_cnt[q*32 +: 32] <= sat_inc(r_drop_cnt[q*32 +: 32]);
            end
            if (w_null_hit) r_null_cnt <= sat_inc(r_null_cnt);
        end
    end

    for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_queue
        nf10_oq_fifo #(
            .WIDTH      (c_FIFO_W),
            .DEPTH_BITS (QUEUE_DEPTH_BITS)
        ) u_fifo (
            .clk     (axi_aclk),
            .rst_n   (axi_resetn),
            .i_wr_en (w_wr_en[q]),
            .i_din   ({s_axis_tlast, s_axis_tuser, s_axis_tstrb, s_axis_tdata}),
            .i_rd_en (w_rd_en[q]),
            .o_dout  (w_fifo_dout[q]),
            .o_empty (w_empty[q]),
            .o_count (w_count[q])
        );

        assign w_room[q]        = (w_count[q] <= c_ADMIT_OCC);
        assign w_rd_en[q]       = m_axis_tready[q] & ~w_empty[q];
        assign m_axis_tvalid[q] = ~w_empty[q];
        assign {m_axis_tlast[q], m_axis_tuser[q*c_UW +: c_UW],
                m_axis_tstrb[q*c_SW +: c_SW], m_axis_tdata[q*c_DW +: c_DW]} = w_fifo_dout[q];
    end

endmodule
`default_nettype wire

// File: tb/tb_nf10_param_output_queues.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nf10_param_output_queues
//  Description : Self-checking bench: packet-level queue model, directed
//                table of packets, hand-written corner sequences, random mix.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nf10_param_output_queues;

    localparam int DW = 32, UW = 32, SW = DW / 8, NQ = 5;
    localparam int QDB = 6, DEPTH = 64, MAXW = 48, LSB = 24;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        logic [UW-1:0] u;
        logic          l;
    } beat_t;

    typedef struct {
        logic [NQ-1:0] bm;
        int            len;
        logic [NQ-1:0] exp_pkt;
        int            exp_null;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0]    s_tdata = '0;
    logic [SW-1:0]    s_tstrb = '0;
    logic [UW-1:0]    s_tuser = '0;
    logic             s_tvalid = 1'b0;
    logic             s_tlast = 1'b0;
    logic             s_tready;
    logic [NQ*DW-1:0] m_tdata;
    logic [NQ*SW-1:0] m_tstrb;
    logic [NQ*UW-1:0] m_tuser;
    logic [NQ-1:0]    m_tvalid;
    logic [NQ-1:0]    m_tready = '1;
    logic [NQ-1:0]    m_tlast;
    logic [NQ*32-1:0] pkt_cnt;
    logic [NQ*32-1:0] drop_cnt;
    logic [31:0]      null_cnt;

    nf10_param_output_queues #(
        .C_AXIS_DATA_WIDTH (DW),
        .C_USER_WIDTH      (UW),
        .NUM_QUEUES        (NQ),
        .QUEUE_DEPTH_BITS  (QDB),
        .MAX_PKT_WORDS     (MAXW),
        .C_DST_LSB         (LSB)
    ) dut (
        .axi_aclk      (clk),
        .axi_resetn    (rst_n),
        .s_axis_tdata  (s_tdata),
        .s_axis_tstrb  (s_tstrb),
        .s_axis_tuser  (s_tuser),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .m_axis_tdata  (m_tdata),
        .m_axis_tstrb  (m_tstrb),
        .m_axis_tuser  (m_tuser),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .pkt_cnt       (pkt_cnt),
        .drop_cnt      (drop_cnt),
        .null_drop_cnt (null_cnt)
    );

    int n_vec = 0;
    int n_err = 0;
    bit rnd = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // ---------------- reference model (packet level) ----------------
    beat_t         mq [NQ][$];
    logic [31:0]   e_pkt [NQ];
    logic [31:0]   e_drop [NQ];
    logic [31:0]   e_null;
    bit            e_rdy;
    bit            in_pkt;
    bit            pkt_keep;
    logic [NQ-1:0] pkt_dst;

    // Compare outputs with the model at the falling edge, then predict the rising edge
    always @(negedge clk) begin : model
        int            occ [NQ];
        logic [NQ-1:0] vexp;
        logic [NQ-1:0] dst;
        beat_t         b;
        if (!rst_n) begin
            for (int q = 0; q < NQ; q++) begin
                mq[q].delete();
                e_pkt[q] = '0;
                e_drop[q] = '0;
            end
            e_null = '0; e_rdy = 1'b0; in_pkt = 1'b0; pkt_keep = 1'b0; pkt_dst = '0;
            check("rst_tready", s_tready, 0);
            check("rst_tvalid", m_tvalid, 0);
            check("rst_counters", {|pkt_cnt, |drop_cnt, |null_cnt}, 0);
        end else begin
            vexp = '0;
            for (int q = 0; q < NQ; q++) begin
                occ[q] = mq[q].size();
                vexp[q] = (occ[q] != 0);
            end
            check("tready", s_tready, e_rdy);
            check("tvalid", m_tvalid, vexp);
            check("null_cnt", null_cnt, e_null);
            for (int q = 0; q < NQ; q++) begin
                check($sformatf("pkt_cnt[%0d]", q), pkt_cnt[q*32 +: 32], e_pkt[q]);
                check($sformatf("drop_cnt[%0d]", q), drop_cnt[q*32 +: 32], e_drop[q]);
                if (m_tvalid[q] && m_tready[q] && occ[q] != 0) begin
                    b = {m_tdata[q*DW +: DW], m_tstrb[q*SW +: SW], m_tuser[q*UW +: UW], m_tlast[q]};
                    check($sformatf("q%0d_beat", q), b, mq[q][0]);
                    void'(mq[q].pop_front());
                end
            end
            if (s_tvalid && e_rdy) begin
                b = {s_tdata, s_tstrb, s_tuser, s_tlast};
                if (!in_pkt) begin
                    dst = s_tuser[LSB +: NQ];
                    pkt_dst = dst;
                    pkt_keep = (dst != '0);
                    for (int q = 0; q < NQ; q++)
                        if (dst[q] && (DEPTH - occ[q]) < MAXW) pkt_keep = 1'b0;
                    if (dst == '0) e_null = sat(e_null);
                    else if (!pkt_keep)
                        for (int q = 0; q < NQ; q++)
                            if (dst[q] && (DEPTH - occ[q]) < MAXW) e_drop[q] = sat(e_drop[q]);
                end
                if (pkt_keep)
                    for (int q = 0; q < NQ; q++)
                        if (pkt_dst[q] && occ[q] < DEPTH) mq[q].push_back(b);
                if (s_tlast) begin
                    if (pkt_keep)
                        for (int q = 0; q < NQ; q++)
                            if (pkt_dst[q]) e_pkt[q] = sat(e_pkt[q]);
                    in_pkt = 1'b0;
                end else begin
                    in_pkt = 1'b1;
                end
            end
            e_rdy = 1'b1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_ready();
        int n;
        n = 0;
        while (!s_tready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("tready_timeout", s_tready, 1);
    endtask

    // Leaves tvalid asserted so consecutive calls are back-to-back
    task automatic send_pkt(input logic [NQ-1:0] bm, input int len);
        for (int i = 0; i < len; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = $urandom;
            s_tstrb  = SW'($urandom);
            s_tuser  = $urandom;
            if (i == 0) s_tuser[LSB +: NQ] = bm;
            s_tlast  = (i == len - 1);
            if (rnd) m_tready = NQ'($urandom);
            @(posedge clk); #1;
        end
    endtask

    task automatic idle(input int cycles);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        repeat (cycles) begin
            if (rnd) m_tready = NQ'($urandom);
            @(posedge clk); #1;
        end
    endtask

    int   x_pkt [NQ];
    int   x_null;
    vec_t tbl [6];
    logic [NQ*32-1:0] frc;

    initial begin
        tbl[0] = '{bm: 5'b00001, len: 1,    exp_pkt: 5'b00001, exp_null: 0};
        tbl[1] = '{bm: 5'b00100, len: 4,    exp_pkt: 5'b00100, exp_null: 0};
        tbl[2] = '{bm: 5'b11111, len: 2,    exp_pkt: 5'b11111, exp_null: 0};
        tbl[3] = '{bm: 5'b00000, len: 1,    exp_pkt: 5'b00000, exp_null: 1};
        tbl[4] = '{bm: 5'b01010, len: 5,    exp_pkt: 5'b01010, exp_null: 0};
        tbl[5] = '{bm: 5'b10000, len: MAXW, exp_pkt: 5'b10000, exp_null: 0};
        for (int q = 0; q < NQ; q++) x_pkt[q] = 0;
        x_null = 0;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_ready();

        // Directed table, all queues ready
        for (int i = 0; i < 6; i++) begin
            send_pkt(tbl[i].bm, tbl[i].len);
            idle(MAXW + 8);
            for (int q = 0; q < NQ; q++) x_pkt[q] += int'(tbl[i].exp_pkt[q]);
            x_null += tbl[i].exp_null;
            for (int q = 0; q < NQ; q++)
                check($sformatf("tbl%0d_pkt[%0d]", i, q), pkt_cnt[q*32 +: 32], x_pkt[q]);
            check($sformatf("tbl%0d_null", i), null_cnt, x_null);
            check($sformatf("tbl%0d_drained", i), m_tvalid, 0);
        end

        // Multicast with one queue back-pressured
        m_tready = 5'b11101;
        send_pkt(5'b10011, 3);
        idle(10);
        check("mc_held", m_tvalid, 5'b00010);
        m_tready = '1;
        idle(6);
        check("mc_drained", m_tvalid, 0);
        x_pkt[0]++; x_pkt[1]++; x_pkt[4]++;
        check("mc_pkt0", pkt_cnt[0 +: 32], x_pkt[0]);
        check("mc_pkt1", pkt_cnt[32 +: 32], x_pkt[1]);
        check("mc_pkt4", pkt_cnt[128 +: 32], x_pkt[4]);

        // Null bitmap followed back-to-back by a single beat to q1
        send_pkt(5'b00000, 1);
        send_pkt(5'b00010, 1);
        idle(4);
        x_null++; x_pkt[1]++;
        check("null_cnt", null_cnt, x_null);
        check("b2b_pkt1", pkt_cnt[32 +: 32], x_pkt[1]);

        // Admission boundary on q3: 16 held still admits, 17 held refuses
        m_tready = 5'b10111;
        send_pkt(5'b01000, 16);
        send_pkt(5'b01000, 1);
        send_pkt(5'b01001, 3);
        idle(5);
        x_pkt[3] += 2;
        check("adm_pkt3", pkt_cnt[96 +: 32], x_pkt[3]);
        check("adm_drop3", drop_cnt[96 +: 32], 1);
        check("adm_drop0", drop_cnt[0 +: 32], 0);
        check("adm_q0_idle", m_tvalid, 5'b01000);
        send_pkt(5'b00001, 2);
        idle(5);
        x_pkt[0]++;
        check("adm_next_pkt0", pkt_cnt[0 +: 32], x_pkt[0]);
        m_tready = '1;
        idle(25);

        // Saturation of drop_cnt[2]
        m_tready = 5'b11011;
        send_pkt(5'b00100, 17);
        idle(2);
        #1;
        e_drop[2] = 32'hFFFF_FFFE;
        frc = {e_drop[4], e_drop[3], 32'hFFFF_FFFE, e_drop[1], e_drop[0]};
        force dut.r_drop_cnt = frc;
        #1;
        release dut.r_drop_cnt;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) send_pkt(5'b00100, 1);
        idle(3);
        check("sat_drop2", drop_cnt[64 +: 32], 32'hFFFF_FFFF);
        m_tready = '1;
        idle(25);

        // Random packets with random output back-pressure
        rnd = 1'b1;
        for (int p = 0; p < 40; p++) begin
            send_pkt(NQ'($urandom_range(0, 31)),
                     ($urandom_range(0, 7) == 0) ? int'($urandom_range(9, MAXW)) : int'($urandom_range(1, 8)));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end
        idle(4);
        rnd = 1'b0;
        m_tready = '1;
        idle(DEPTH + 4);
        check("rnd_drained", m_tvalid, 0);

        // Reset during beat 3 of a 10-beat packet to q0
        for (int i = 0; i < 10; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = $urandom;
            s_tstrb  = SW'($urandom);
            s_tuser  = $urandom;
            if (i == 0) s_tuser[LSB +: NQ] = 5'b00001;
            s_tlast  = (i == 9);
            if (i == 2) begin
                rst_n = 1'b0;
                s_tvalid = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_mid_tvalid", m_tvalid, 0);
        check("rst_mid_pkt", pkt_cnt, 0);
        check("rst_mid_tready", s_tready, 0);
        rst_n = 1'b1;
        wait_ready();
        send_pkt(5'b00001, 2);
        idle(5);
        check("rst_next_pkt0", pkt_cnt[0 +: 32], 1);
        check("rst_next_drained", m_tvalid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
